// File: rtl/cache_dfp_arbiter_if.sv
// Cacheline-wide memory port bundle. A cache's dfp side is the master (drives the
// request, receives data/resp); the arbiter's memory side is also a master toward
// the memory model or burst adapter.
interface cache_dfp_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic [ADDR_W-1:0] addr;
  logic              read;
  logic              write;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              resp;

  modport master (output addr, read, write, wdata, input rdata, resp);
  modport slave  (input addr, read, write, wdata, output rdata, resp);
endinterface

// File: rtl/cache_dfp_arbiter.sv
// cache_dfp_arbiter: shares one cacheline memory port between the instruction and
// data caches. One requester is granted at a time, the grant is held until the
// memory responds, and completed transactions are counted per requester.

// Protocol checks on the requester sides of the arbiter.
module cache_dfp_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic gnt_i,
  input logic gnt_d,
  input logic i_read,
  input logic i_write,
  input logic d_read,
  input logic d_write,
  input logic mem_resp
);
  // A granted requester must keep its request up until the memory responds.
  a_i_hold: assert property (@(posedge clk) disable iff (rst)
    (gnt_i && !mem_resp) |-> (i_read || i_write));
  a_d_hold: assert property (@(posedge clk) disable iff (rst)
    (gnt_d && !mem_resp) |-> (d_read || d_write));
  // Read and write are mutually exclusive on each side.
  a_i_rw: assert property (@(posedge clk) disable iff (rst) !(i_read && i_write));
  a_d_rw: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
endmodule

module cache_dfp_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter bit RR_EN  = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  cache_dfp_arbiter_if.slave  i_dfp,
  cache_dfp_arbiter_if.slave  d_dfp,
  cache_dfp_arbiter_if.master mem,
  output logic [CNT_W-1:0]    i_count,
  output logic [CNT_W-1:0]    d_count
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  state_t state_r;
  state_t state_nxt_s;
  logic   last_gnt_r;
  logic   i_req_s;
  logic   d_req_s;
  logic   i_done_s;
  logic   d_done_s;

  assign i_req_s  = i_dfp.read | i_dfp.write;
  assign d_req_s  = d_dfp.read | d_dfp.write;
  assign i_done_s = (state_r == GNT_I) & mem.resp;
  assign d_done_s = (state_r == GNT_D) & mem.resp;

  // Read data is broadcast to both caches; only the granted side sees a resp.
  assign i_dfp.rdata = mem.rdata;
  assign d_dfp.rdata = mem.rdata;

  // State, last-grant and completion-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      last_gnt_r <= LAST_I;
      i_count    <= {CNT_W{1'b0}};
      d_count    <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (i_done_s) begin
        last_gnt_r <= LAST_I;
        i_count    <= i_count + CNT_W'(1'b1);
      end else if (d_done_s) begin
        last_gnt_r <= LAST_D;
        d_count    <= d_count + CNT_W'(1'b1);
      end
    end
  end

  // Arbitration decode and steering of the memory port to the granted cache.
  always_comb begin
    state_nxt_s = state_r;
    mem.addr    = {ADDR_W{1'b0}};
    mem.read    = 1'b0;
    mem.write   = 1'b0;
    mem.wdata   = {LINE_W{1'b0}};
    i_dfp.resp  = 1'b0;
    d_dfp.resp  = 1'b0;
    case (state_r)
      IDLE: begin
        // Grant is registered: requests never reach mem_read/mem_write in this cycle.
        if (i_req_s && d_req_s) begin
          if (RR_EN == 1'b1) begin
            if (last_gnt_r == LAST_I) begin
              state_nxt_s = GNT_D;
            end else begin
              state_nxt_s = GNT_I;
            end
          end else begin
            state_nxt_s = GNT_D;
          end
        end else if (i_req_s) begin
          state_nxt_s = GNT_I;
        end else if (d_req_s) begin
          state_nxt_s = GNT_D;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT_I: begin
        mem.addr   = i_dfp.addr;
        mem.read   = i_dfp.read;
        mem.write  = i_dfp.write;
        mem.wdata  = i_dfp.wdata;
        i_dfp.resp = mem.resp;
        if (mem.resp) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GNT_I;
        end
      end
      GNT_D: begin
        mem.addr   = d_dfp.addr;
        mem.read   = d_dfp.read;
        mem.write  = d_dfp.write;
        mem.wdata  = d_dfp.wdata;
        d_dfp.resp = mem.resp;
        if (mem.resp) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GNT_D;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  cache_dfp_arbiter_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .gnt_i    (state_r == GNT_I),
    .gnt_d    (state_r == GNT_D),
    .i_read   (i_dfp.read),
    .i_write  (i_dfp.write),
    .d_read   (d_dfp.read),
    .d_write  (d_dfp.write),
    .mem_resp (mem.resp)
  );
endmodule

// File: tb/tb_cache_dfp_arbiter.sv
// Bench for cache_dfp_arbiter. Two instances: [0] round-robin with 32-bit counters,
// [1] fixed priority with 4-bit counters. Requests come from per-side queues, the
// expected completion order is pushed to a scoreboard and checked on each resp.
module tb_cache_dfp_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] i_addr_v [2], d_addr_v [2], mem_addr_v [2];
  logic          i_read_v [2], i_write_v [2], d_read_v [2], d_write_v [2];
  logic [LW-1:0] i_wdata_v [2], d_wdata_v [2], mem_wdata_v [2];
  logic [LW-1:0] i_rdata_v [2], d_rdata_v [2];
  logic          i_resp_v [2], d_resp_v [2], mem_read_v [2], mem_write_v [2];
  logic          stray_v [2];
  logic [31:0]   i_cnt_v [2], d_cnt_v [2];
  int            lat_v [2];

  function automatic logic [LW-1:0] mem_pat(input logic [AW-1:0] a);
    return {8{a ^ 32'h5A5A_A5A5}};
  endfunction

  function automatic logic [LW-1:0] wdata_of(input logic wr, input logic [AW-1:0] a);
    return wr ? {8{a ^ 32'hC0DE_0000}} : {LW{1'b0}};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int CW = (g == 0) ? 32 : 4;
    cache_dfp_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) i_if ();
    cache_dfp_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) d_if ();
    cache_dfp_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) m_if ();
    logic [CW-1:0] ic, dc;
    logic          mresp_r;
    int            cnt_r;

    assign i_if.addr  = i_addr_v[g];
    assign i_if.read  = i_read_v[g];
    assign i_if.write = i_write_v[g];
    assign i_if.wdata = i_wdata_v[g];
    assign d_if.addr  = d_addr_v[g];
    assign d_if.read  = d_read_v[g];
    assign d_if.write = d_write_v[g];
    assign d_if.wdata = d_wdata_v[g];
    assign i_rdata_v[g]   = i_if.rdata;
    assign i_resp_v[g]    = i_if.resp;
    assign d_rdata_v[g]   = d_if.rdata;
    assign d_resp_v[g]    = d_if.resp;
    assign mem_addr_v[g]  = m_if.addr;
    assign mem_read_v[g]  = m_if.read;
    assign mem_write_v[g] = m_if.write;
    assign mem_wdata_v[g] = m_if.wdata;
    assign m_if.rdata = mem_pat(m_if.addr);
    assign m_if.resp  = mresp_r | stray_v[g];
    assign i_cnt_v[g] = 32'(ic);
    assign d_cnt_v[g] = 32'(dc);

    cache_dfp_arbiter #(.ADDR_W(AW), .LINE_W(LW), .RR_EN(g == 0), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .i_dfp(i_if), .d_dfp(d_if), .mem(m_if),
      .i_count(ic), .d_count(dc)
    );

    // Memory model: resp pulses lat_v cycles after read/write is first seen.
    always @(posedge clk) begin
      if (rst) begin
        mresp_r <= 1'b0;
        cnt_r   <= 0;
      end else if (mresp_r) begin
        mresp_r <= 1'b0;
        cnt_r   <= 0;
      end else if (m_if.read | m_if.write) begin
        if (cnt_r >= lat_v[g] - 1) begin
          mresp_r <= 1'b1;
          cnt_r   <= 0;
        end else begin
          cnt_r <= cnt_r + 1;
        end
      end else begin
        cnt_r <= 0;
      end
    end
  end

  typedef struct { logic wr; logic [AW-1:0] addr; } req_t;
  typedef struct { int g; logic side; logic wr; logic [AW-1:0] addr; } exp_t;
  typedef struct { int g; int i_op; int d_op; logic d_first; } vec_t;

  req_t        rq [4][$];          // index = dut*2 + side (0 = I, 1 = D)
  logic        act [4];
  exp_t        eq [$];
  logic        pend [2];
  logic        pend_side [2];
  logic [31:0] exp_ic [2], exp_dc [2];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [LW-1:0] act_v, input logic [LW-1:0] exp_v);
    n_vec++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act_v, exp_v);
    end
  endtask

  function automatic logic [31:0] cmask(input int g);
    return (g == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
  endfunction

  function automatic logic busy();
    for (int k = 0; k < 4; k++) if (act[k] || rq[k].size() != 0) return 1'b1;
    for (int g = 0; g < 2; g++) if (pend[g]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input int k);
    int g; logic rd, wr; logic [AW-1:0] a;
    g = k / 2; rd = 1'b0; wr = 1'b0; a = '0;
    if (act[k]) begin
      wr = rq[k][0].wr; rd = ~rq[k][0].wr; a = rq[k][0].addr;
    end
    if (k % 2 == 0) begin
      i_read_v[g] = rd; i_write_v[g] = wr; i_addr_v[g] = a; i_wdata_v[g] = wdata_of(wr, a);
    end else begin
      d_read_v[g] = rd; d_write_v[g] = wr; d_addr_v[g] = a; d_wdata_v[g] = wdata_of(wr, a);
    end
  endtask

  task automatic load_all();
    for (int k = 0; k < 4; k++) begin
      if (!act[k] && rq[k].size() != 0) act[k] = 1'b1;
      drive(k);
    end
  endtask

  task automatic req(input int g, input int side, input logic wr, input logic [AW-1:0] a);
    req_t r; r.wr = wr; r.addr = a;
    rq[g * 2 + side].push_back(r);
  endtask

  task automatic expect_txn(input int g, input logic side, input logic wr, input logic [AW-1:0] a);
    exp_t e; e.g = g; e.side = side; e.wr = wr; e.addr = a;
    eq.push_back(e);
  endtask

  task automatic monitor(input int g);
    exp_t e; int k; logic [1:0] got;
    got = {i_resp_v[g], d_resp_v[g]};
    if (pend[g]) begin
      chk("resp_pulse_width", 256'(got), 256'(0));
      chk("i_count", 256'(i_cnt_v[g]), 256'(exp_ic[g]));
      chk("d_count", 256'(d_cnt_v[g]), 256'(exp_dc[g]));
      k = g * 2 + (pend_side[g] ? 1 : 0);
      if (act[k]) begin
        void'(rq[k].pop_front());
        act[k] = 1'b0;
      end
      pend[g] = 1'b0;
    end else if (got != 2'b00) begin
      if (eq.size() == 0 || eq[0].g != g) begin
        chk("unexpected_resp", 256'(got), 256'(0));
      end else begin
        e = eq.pop_front();
        chk("resp_side", 256'(got), e.side ? 256'(2'b01) : 256'(2'b10));
        chk("mem_addr", 256'(mem_addr_v[g]), 256'(e.addr));
        chk("mem_rw", 256'({mem_read_v[g], mem_write_v[g]}), 256'({~e.wr, e.wr}));
        chk("mem_wdata", mem_wdata_v[g], wdata_of(e.wr, e.addr));
        chk("rdata", e.side ? d_rdata_v[g] : i_rdata_v[g], mem_pat(e.addr));
        if (e.side) exp_dc[g] = (exp_dc[g] + 32'd1) & cmask(g);
        else        exp_ic[g] = (exp_ic[g] + 32'd1) & cmask(g);
        pend[g] = 1'b1;
        pend_side[g] = got[0];
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int g = 0; g < 2; g++) monitor(g);
    load_all();
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((eq.size() != 0 || busy()) && n < bound) begin
      cycle();
      n++;
    end
    chk("drain", 256'({eq.size() != 0, busy()}), 256'(0));
  endtask

  task automatic clear_bench();
    eq.delete();
    for (int k = 0; k < 4; k++) begin
      rq[k].delete(); act[k] = 1'b0; drive(k);
    end
    for (int g = 0; g < 2; g++) begin
      pend[g] = 1'b0; pend_side[g] = 1'b0; exp_ic[g] = 32'd0; exp_dc[g] = 32'd0;
      stray_v[g] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_bench();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl [8];
  int   n;

  initial begin
    lat_v[0] = 10; lat_v[1] = 2;
    clear_bench();
    tbl[0] = '{0, 1, 1, 1'b0};
    tbl[1] = '{0, 0, 2, 1'b1};
    tbl[2] = '{0, 1, 0, 1'b0};
    tbl[3] = '{0, 2, 1, 1'b1};
    tbl[4] = '{1, 1, 1, 1'b1};
    tbl[5] = '{1, 2, 2, 1'b1};
    tbl[6] = '{1, 1, 0, 1'b0};
    tbl[7] = '{0, 1, 1, 1'b1};

    // Reset state of both instances.
    do_reset();
    for (int g = 0; g < 2; g++) begin
      chk("rst_mem_rw", 256'({mem_read_v[g], mem_write_v[g]}), 256'(0));
      chk("rst_mem_addr", 256'(mem_addr_v[g]), 256'(0));
      chk("rst_resp", 256'({i_resp_v[g], d_resp_v[g]}), 256'(0));
      chk("rst_counts", 256'({i_cnt_v[g], d_cnt_v[g]}), 256'(0));
    end

    // Single icache read: one cycle of arbitration, memory answers 10 cycles later.
    req(0, 0, 1'b0, 32'h0000_1000);
    expect_txn(0, 1'b0, 1'b0, 32'h0000_1000);
    load_all();
    #1;
    chk("t1_no_comb_path", 256'(mem_read_v[0]), 256'(0));
    cycle();
    chk("t1_grant_latency", 256'(mem_read_v[0]), 256'(1));
    for (n = 1; n <= 20; n++) begin
      cycle();
      if (i_resp_v[0] == 1'b1) break;
    end
    chk("t1_resp_latency", 256'(n), 256'(10));
    wait_idle(50);
    chk("t1_i_count", 256'(i_cnt_v[0]), 256'(1));

    // Simultaneous reads after reset: D first, then I.
    do_reset();
    lat_v[0] = 3;
    req(0, 0, 1'b0, 32'h0000_3000);
    req(0, 1, 1'b0, 32'h0000_5000);
    expect_txn(0, 1'b1, 1'b0, 32'h0000_5000);
    expect_txn(0, 1'b0, 1'b0, 32'h0000_3000);
    load_all();
    wait_idle(100);

    // Writeback then refill, interleaved with a held icache read.
    lat_v[0] = 4;
    req(0, 1, 1'b1, 32'h0000_2040);
    req(0, 1, 1'b0, 32'h0000_4040);
    req(0, 0, 1'b0, 32'h0000_6000);
    expect_txn(0, 1'b1, 1'b1, 32'h0000_2040);
    expect_txn(0, 1'b0, 1'b0, 32'h0000_6000);
    expect_txn(0, 1'b1, 1'b0, 32'h0000_4040);
    load_all();
    wait_idle(150);

    // Arbitration table: requests raised together from IDLE.
    for (int v = 0; v < 8; v++) begin
      logic [AW-1:0] ia, da;
      int g;
      g = tbl[v].g;
      ia = 32'h0001_0000 + 32'(v) * 32'h40;
      da = 32'h0002_0000 + 32'(v) * 32'h40;
      lat_v[g] = 2 + (v % 3);
      if (tbl[v].i_op != 0) req(g, 0, tbl[v].i_op == 2, ia);
      if (tbl[v].d_op != 0) req(g, 1, tbl[v].d_op == 2, da);
      if (tbl[v].d_op != 0 && (tbl[v].d_first || tbl[v].i_op == 0))
        expect_txn(g, 1'b1, tbl[v].d_op == 2, da);
      if (tbl[v].i_op != 0) expect_txn(g, 1'b0, tbl[v].i_op == 2, ia);
      if (tbl[v].d_op != 0 && !tbl[v].d_first && tbl[v].i_op != 0)
        expect_txn(g, 1'b1, tbl[v].d_op == 2, da);
      load_all();
      wait_idle(200);
    end

    // Reset three cycles into a dcache grant: no resp, counters cleared.
    lat_v[0] = 20;
    req(0, 1, 1'b0, 32'h0000_7000);
    load_all();
    n = 0;
    while (mem_read_v[0] !== 1'b1 && n < 10) begin
      cycle();
      n++;
    end
    chk("t5_granted", 256'(mem_read_v[0]), 256'(1));
    cycle();
    cycle();
    rst = 1'b1;
    clear_bench();
    cycle();
    chk("t5_mem_read", 256'(mem_read_v[0]), 256'(0));
    chk("t5_resp", 256'({i_resp_v[0], d_resp_v[0]}), 256'(0));
    chk("t5_counts", 256'({i_cnt_v[0], d_cnt_v[0]}), 256'(0));
    rst = 1'b0;
    for (int i = 0; i < 30; i++) cycle();
    chk("t5_stays_idle", 256'({mem_read_v[0], d_resp_v[0]}), 256'(0));

    // Fixed priority: D wins three times in a row, I waits.
    do_reset();
    lat_v[1] = 2;
    req(1, 0, 1'b0, 32'h0000_9000);
    for (int i = 0; i < 3; i++) begin
      req(1, 1, 1'b0, 32'h0000_A000 + 32'(i) * 32'h20);
      expect_txn(1, 1'b1, 1'b0, 32'h0000_A000 + 32'(i) * 32'h20);
    end
    expect_txn(1, 1'b0, 1'b0, 32'h0000_9000);
    load_all();
    wait_idle(300);

    // 4-bit counter wraps after 16 completions; stray resp in IDLE is ignored.
    do_reset();
    lat_v[1] = 1;
    for (int i = 0; i < 16; i++) begin
      req(1, 0, 1'b0, 32'h0000_8000 + 32'(i) * 32'h20);
      expect_txn(1, 1'b0, 1'b0, 32'h0000_8000 + 32'(i) * 32'h20);
    end
    load_all();
    wait_idle(400);
    chk("t6_wrap", 256'(i_cnt_v[1]), 256'(0));
    stray_v[1] = 1'b1;
    #1;
    chk("t6_stray_resp", 256'({i_resp_v[1], d_resp_v[1]}), 256'(0));
    cycle();
    stray_v[1] = 1'b0;
    cycle();
    chk("t6_stray_counts", 256'({i_cnt_v[1], d_cnt_v[1]}), 256'(0));
    chk("t6_stray_idle", 256'({mem_read_v[1], mem_write_v[1]}), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
